// File: rtl/div_pkg.sv
// Shared types and constants for the divide quotient fixer.
// Contents: FSM state enum, datapath widths, per-precision fraction widths K.
package div_pkg;

  localparam int SIG_W  = 53;           // significand width, 1.52 fixed point
  localparam int FQ_W   = 57;           // approximate quotient width, 1.56
  localparam int REM_W  = 110;          // signed remainder width
  localparam int DBL_K  = 55;           // fraction bits kept for double
  localparam int SGL_K  = 26;           // fraction bits kept for single
  localparam int QT_W   = DBL_K + 1;    // widest truncated quotient (K+1 bits)
  localparam int PROD_W = QT_W + SIG_W; // qt * fb product width
  localparam int CNT_W  = 6;            // holds iteration counts up to 56

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    REM,
    DONE
  } state_t;

endpackage

// File: rtl/div_quot_fix_if.sv
// Handshake bundle between the Newton-Raphson front end, the quotient fixer
// and the rounder.
// master: drives in_valid/fa/fb/fq/db and out_ready.
// slave : drives in_ready and out_valid/q_out/sticky (and err when
//         DIV_QUOT_FIX_CHECK_EN is defined).
interface div_quot_fix_if;
  import div_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [SIG_W-1:0]  fa;
  logic [SIG_W-1:0]  fb;
  logic [FQ_W-1:0]   fq;
  logic              db;
  logic              out_valid;
  logic              out_ready;
  logic [FQ_W-1:0]   q_out;
  logic              sticky;
`ifdef DIV_QUOT_FIX_CHECK_EN
  logic              err;

  modport master (output in_valid, fa, fb, fq, db, out_ready,
                  input  in_ready, out_valid, q_out, sticky, err);
  modport slave  (input  in_valid, fa, fb, fq, db, out_ready,
                  output in_ready, out_valid, q_out, sticky, err);
`else
  modport master (output in_valid, fa, fb, fq, db, out_ready,
                  input  in_ready, out_valid, q_out, sticky);
  modport slave  (input  in_valid, fa, fb, fq, db, out_ready,
                  output in_ready, out_valid, q_out, sticky);
`endif

endinterface

// File: rtl/div_seq_mul.sv
// Radix-2 sequential shift-add multiplier, LSB first, one multiplier bit
// per clock.
// Ports: clk, rst_n; start loads a (multiplier), b (multiplicand) and
// nbits (number of multiplier bits to consume); done is high during the
// cycle that performs the final step, so prod is complete after that edge.
module div_seq_mul
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [QT_W-1:0]   a,
  input  logic [SIG_W-1:0]  b,
  input  logic [CNT_W-1:0]  nbits,
  output logic              done,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand;
  logic [QT_W-1:0]   mplier;
  logic [CNT_W-1:0]  cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= PROD_W'(b);
      mplier <= a;
      cnt    <= nbits;
    end else if (cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));
  assign prod = acc;

endmodule

// File: rtl/div_quot_fix.sv
// Quotient fixer: takes the Newton-Raphson approximation fq of fa/fb,
// truncates it to K fraction bits, forms the exact remainder
// R = fa*2^K - qt*fb with a sequential multiplier and applies a +/-1 ulp
// correction, producing a truncated quotient and a sticky bit.
// Ports: clk, rst_n (async, active low); bus (slave side of
// div_quot_fix_if: in_valid/in_ready/fa/fb/fq/db in,
// out_valid/out_ready/q_out/sticky out).
// Optional: DIV_QUOT_FIX_CHECK_EN adds bus.err, flagging approximations
// too far off for a one-ulp fix, plus an assertion on out_valid && err.
module div_quot_fix
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  div_quot_fix_if.slave bus
);

  state_t state, state_nxt;

  logic [SIG_W-1:0]  fa_int, fb_int;
  logic              db_int;
  logic [QT_W-1:0]   qt_int;
  logic [FQ_W-1:0]   q_reg;
  logic              sticky_reg;

  logic              accept;
  logic              mul_start, mul_done;
  logic [QT_W-1:0]   qt_in;
  logic [CNT_W-1:0]  nbits_in;
  logic [PROD_W-1:0] prod;

  logic signed [REM_W-1:0] fa_sh, fb_s, r, r2;
  logic [QT_W-1:0]   q_fix;
  logic              sticky_fix;
  logic [FQ_W-1:0]   q_align;

  // Truncate fq to K fraction bits, right-aligned in qt.
  assign qt_in    = QT_W'(bus.fq >> (bus.db ? (FQ_W - 1 - DBL_K) : (FQ_W - 1 - SGL_K)));
  assign nbits_in = bus.db ? CNT_W'(DBL_K + 1) : CNT_W'(SGL_K + 1);
  assign accept   = (state == IDLE) && bus.in_valid;

  div_seq_mul u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (qt_in),
    .b     (bus.fb),
    .nbits (nbits_in),
    .done  (mul_done),
    .prod  (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    mul_start     = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          mul_start = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL:  if (mul_done) state_nxt = REM;
      REM:  state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remainder and correction. Both operands are non-negative magnitudes,
  // zero-extended into the signed remainder width.
  assign fa_sh = db_int ? (REM_W'(fa_int) << DBL_K) : (REM_W'(fa_int) << SGL_K);
  assign fb_s  = REM_W'(fb_int);
  assign r     = fa_sh - REM_W'(prod);
  assign r2    = r - fb_s;

  always_comb begin
    q_fix      = qt_int;
    sticky_fix = 1'b0;
    if (r < 0) begin
      q_fix      = qt_int - QT_W'(1);
      sticky_fix = 1'b1;
    end else if (r == 0) begin
      q_fix      = qt_int;
      sticky_fix = 1'b0;
    end else if (r2 < 0) begin
      q_fix      = qt_int;
      sticky_fix = 1'b1;
    end else begin
      q_fix      = qt_int + QT_W'(1);
      sticky_fix = (r2 != 0);
    end
  end

  // Left-align to bit 56; bits below 2^-K are zero.
  assign q_align = db_int ? {q_fix, 1'b0}
                          : {q_fix[SGL_K:0], {(FQ_W - 1 - SGL_K){1'b0}}};

  // NOTE: the datapath registers are reset as well so a mid-operation reset
  // leaves no stale operands or results visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_int     <= '0;
      fb_int     <= '0;
      db_int     <= 1'b0;
      qt_int     <= '0;
      q_reg      <= '0;
      sticky_reg <= 1'b0;
    end else begin
      if (accept) begin
        fa_int <= bus.fa;
        fb_int <= bus.fb;
        db_int <= bus.db;
        qt_int <= qt_in;
      end
      if (state == REM) begin
        q_reg      <= q_align;
        sticky_reg <= sticky_fix;
      end
    end
  end

  assign bus.q_out  = q_reg;
  assign bus.sticky = sticky_reg;

`ifdef DIV_QUOT_FIX_CHECK_EN
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err_reg <= 1'b0;
    else if (state == REM)   err_reg <= (r < -fb_s) || (r2 >= fb_s);
  end

  assign bus.err = err_reg;

  a_no_err: assert property (@(posedge clk) disable iff (!rst_n)
                             !(bus.out_valid && bus.err));
`endif

endmodule

// File: tb/tb_div_quot_fix.sv
// Self-checking bench for div_quot_fix: directed cases plus randomized
// operands checked against an exact-division reference model.
module tb_div_quot_fix;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_quot_fix_if bus();

  div_quot_fix dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [52:0] ONE    = 53'h10000000000000;
  localparam logic [52:0] ONE_P5 = 53'h18000000000000;

  task automatic check(input string tag, input logic [56:0] obs, input logic [56:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact quotient truncated to K fraction bits, left-aligned,
  // sticky when the division is inexact.
  task automatic model(input logic [52:0] fa, input logic [52:0] fb, input logic db,
                       output logic [56:0] q_exp, output logic s_exp);
    int k;
    logic [109:0] num, quo, rem;
    k     = db ? 55 : 26;
    num   = 110'(fa) << k;
    quo   = num / 110'(fb);
    rem   = num % 110'(fb);
    q_exp = 57'(quo << (56 - k));
    s_exp = (rem != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [52:0] fa, input logic [52:0] fb,
                      input logic [56:0] fq, input logic db);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("in_ready_wait", 57'(n < 300), 57'(1));
    bus.fa       = fa;
    bus.fb       = fb;
    bus.fq       = fq;
    bus.db       = db;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat);
    int lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    check("latency", 57'(lat), 57'(exp_lat));
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("idle_out_valid", 57'(bus.out_valid), 57'(0));
    check("idle_in_ready", 57'(bus.in_ready), 57'(1));
  endtask

  task automatic run(input string tag, input logic [52:0] fa, input logic [52:0] fb,
                     input logic [56:0] fq, input logic db);
    logic [56:0] q_exp;
    logic        s_exp;
    model(fa, fb, db, q_exp, s_exp);
    send(fa, fb, fq, db);
    wait_out(db ? 57 : 28);
    check({tag, "_q"}, bus.q_out, q_exp);
    check({tag, "_sticky"}, 57'(bus.sticky), 57'(s_exp));
    release_out();
  endtask

  // fq within the precondition: exact*2^56 plus an offset below 2^(56-K).
  task automatic make_fq(input logic [52:0] fa, input logic [52:0] fb, input logic db,
                         output logic [56:0] fq);
    logic [109:0] ex;
    longint off;
    ex = (110'(fa) << 56) / 110'(fb);
    if (db) off = longint'($urandom_range(0, 2)) - 1;
    else    off = longint'($urandom_range(0, 32'h7FFF_FFFE)) - 64'h3FFF_FFFF;
    if (off < 0) fq = 57'(ex - 110'(-off));
    else         fq = 57'(ex + 110'(off));
  endtask

  initial begin
    logic [56:0] fq23, fq_r, q_exp, q_hold;
    logic        s_exp, s_hold;
    logic [52:0] fa, fb;
    logic        db;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fa        = '0;
    bus.fb        = '0;
    bus.fq        = '0;
    bus.db        = 1'b0;
    rst_n         = 1'b0;
    step();
    step();
    check("rst_in_ready", 57'(bus.in_ready), 57'(1));
    check("rst_out_valid", 57'(bus.out_valid), 57'(0));
    check("rst_q_out", bus.q_out, 57'(0));
    check("rst_sticky", 57'(bus.sticky), 57'(0));
    rst_n = 1'b1;
    step();

    // 1: exact 1/1 double.
    run("t1", ONE, ONE, 57'h100000000000000, 1'b1);

    // 2/3: 1/1.5 with exact-truncated fq, one ulp high, one ulp low.
    fq23 = 57'((((110'(1) << 55) * 2) / 3) << 1);
    run("t2", ONE, ONE_P5, fq23, 1'b1);
    run("t3_high", ONE, ONE_P5, fq23 + 57'd2, 1'b1);
    run("t3_low", ONE, ONE_P5, fq23 - 57'd2, 1'b1);

    // 4: single 1/1, latency 28, low bits clear.
    run("t4", ONE, ONE, 57'h100000000000000, 1'b0);
    send(ONE, ONE_P5, fq23, 1'b0);
    wait_out(28);
    check("t4_low_zero", 57'(bus.q_out[29:0]), 57'(0));
    release_out();

    // 5: downstream stall with a competing in_valid.
    model(ONE, ONE_P5, 1'b1, q_exp, s_exp);
    send(ONE, ONE_P5, fq23, 1'b1);
    wait_out(57);
    q_hold = bus.q_out;
    s_hold = bus.sticky;
    check("t5_q", q_hold, q_exp);
    bus.fa       = ONE;
    bus.fb       = ONE;
    bus.fq       = 57'h100000000000000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_out_valid", 57'(bus.out_valid), 57'(1));
      check("t5_q_stable", bus.q_out, q_exp);
      check("t5_sticky_stable", 57'(bus.sticky), 57'(s_exp));
      check("t5_in_ready", 57'(bus.in_ready), 57'(0));
    end
    bus.in_valid = 1'b0;
    release_out();
    step();
    check("t5_not_accepted", 57'(bus.in_ready), 57'(1));

    // 6: reset in the middle of MUL, then a clean transaction.
    send(ONE, ONE_P5, fq23, 1'b1);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 57'(bus.out_valid), 57'(0));
    check("t6_in_ready", 57'(bus.in_ready), 57'(1));
    check("t6_q_out", bus.q_out, 57'(0));
    step();
    rst_n = 1'b1;
    step();
    run("t6_after", ONE, ONE_P5, fq23 + 57'd1, 1'b1);

    // Random operands in [1,2) for both precisions.
    for (int i = 0; i < 16; i++) begin
      db = 1'(i % 2);
      fa = {1'b1, 52'({$urandom, $urandom})};
      fb = {1'b1, 52'({$urandom, $urandom})};
      if (!db) begin
        fa[28:0] = '0;
        fb[28:0] = '0;
      end
      make_fq(fa, fb, db, fq_r);
      run("rand", fa, fb, fq_r, db);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
